// File: rtl/decode_pkg.sv
// Shared RV32I decode constants: major opcodes, format codes and funct7 encodings.
// Imported by the decode stage and the immediate generator.
package decode_pkg;

   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   typedef enum logic [2:0] {
      FMT_R    = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_NONE = 3'd7
   } fmt_e;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: assembles the format-specific immediate
// and sign-extends it from instr[31] to XLEN. Unknown formats produce 0.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     i_instr,
   input  logic [2:0]      i_fmt,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_imm32;
   logic        w_unused;

   // The opcode bits never contribute to an immediate.
   assign w_unused = ^i_instr[6:0];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      w_imm32 = '0;
      case (i_fmt)
         FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
         FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
         FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                             i_instr[30:25], i_instr[11:8], 1'b0};
         FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
         FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                             i_instr[20], i_instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: classifies the incoming word, builds its immediate
// and holds the result in one output register bank under valid/ready control.
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter bit ENABLE_M = 1'b0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [6:0]      opcode,
   output logic [4:0]      rd,
   output logic [2:0]      funct3,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            rd_we,
   output logic            illegal
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   fmt_e            w_fmt;
   logic            w_we;
   logic            w_illegal;
   logic [XLEN-1:0] w_imm;
   logic            w_capture;

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_imm;
   logic [2:0]      r_fmt;
   logic            r_rd_we;
   logic            r_illegal;

   assign w_opcode = in_instr[6:0];
   assign w_funct3 = in_instr[14:12];
   assign w_funct7 = in_instr[31:25];

   always_comb begin
      w_fmt     = FMT_NONE;
      w_we      = 1'b0;
      w_illegal = 1'b0;
      case (w_opcode)
         OP: begin
            w_fmt = FMT_R;
            w_we  = 1'b1;
            // SUB/SRA are the only alternate-encoding R-type ops in the base set.
            if (!((w_funct7 == F7_BASE) ||
                  (w_funct7 == F7_ALT && (w_funct3 == 3'b000 || w_funct3 == 3'b101)) ||
                  (ENABLE_M && w_funct7 == F7_MULDIV)))
               w_illegal = 1'b1;
         end
         OP_IMM: begin
            w_fmt = FMT_I;
            w_we  = 1'b1;
            if (w_funct3 == 3'b001 && w_funct7 != F7_BASE)
               w_illegal = 1'b1;
            if (w_funct3 == 3'b101 && w_funct7 != F7_BASE && w_funct7 != F7_ALT)
               w_illegal = 1'b1;
         end
         LOAD, JALR: begin
            w_fmt = FMT_I;
            w_we  = 1'b1;
         end
         SYSTEM: begin
            w_fmt = FMT_I;
            w_we  = (w_funct3 != 3'b000);
         end
         MISC_MEM: w_fmt = FMT_I;
         STORE:    w_fmt = FMT_S;
         BRANCH:   w_fmt = FMT_B;
         LUI, AUIPC: begin
            w_fmt = FMT_U;
            w_we  = 1'b1;
         end
         JAL: begin
            w_fmt = FMT_J;
            w_we  = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
      if (in_instr[1:0] != 2'b11)
         w_illegal = 1'b1;
      if (w_illegal) begin
         w_fmt = FMT_NONE;
         w_we  = 1'b0;
      end
   end

   imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .i_instr (in_instr),
      .i_fmt   (w_fmt),
      .o_imm   (w_imm)
   );

   assign in_ready  = !r_valid || out_ready;
   assign w_capture = in_valid && in_ready && !flush;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_instr   <= '0;
         r_imm     <= '0;
         r_fmt     <= FMT_NONE;
         r_rd_we   <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_capture) begin
         r_valid   <= 1'b1;
         r_pc      <= in_pc;
         r_instr   <= in_instr;
         r_imm     <= w_imm;
         r_fmt     <= w_fmt;
         r_rd_we   <= w_we && (in_instr[11:7] != 5'd0);
         r_illegal <= w_illegal;
      end else if (flush || out_ready) begin
         r_valid   <= 1'b0;
      end
   end

   assign out_valid = r_valid;
   assign out_pc    = r_pc;
   assign opcode    = r_instr[6:0];
   assign rd        = r_instr[11:7];
   assign funct3    = r_instr[14:12];
   assign rs1       = r_instr[19:15];
   assign rs2       = r_instr[24:20];
   assign funct7    = r_instr[31:25];
   assign imm       = r_imm;
   assign fmt       = r_fmt;
   assign rd_we     = r_rd_we;
   assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: three instances (base, M-enabled, XLEN=64) share one
// stimulus stream; a negedge monitor pops expected bundles on every output handshake.
module tb_decode_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [63:0] imm64;
      logic [2:0]  fmt;
      logic [2:0]  fmt_m;
      logic        rd_we;
      logic        rd_we_m;
      logic        ill;
      logic        ill_m;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;
   logic [63:0] in_pc64;

   logic        in_ready, out_valid, rd_we, illegal;
   logic [31:0] out_pc, imm;
   logic [6:0]  opcode, funct7;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3, fmt;

   logic        m_in_ready, m_out_valid, m_rd_we, m_illegal;
   logic [31:0] m_out_pc, m_imm;
   logic [6:0]  m_opcode, m_funct7;
   logic [4:0]  m_rd, m_rs1, m_rs2;
   logic [2:0]  m_funct3, m_fmt;

   logic        w64_in_ready, w64_out_valid, w64_rd_we, w64_illegal;
   logic [63:0] w64_out_pc, w64_imm;
   logic [6:0]  w64_opcode, w64_funct7;
   logic [4:0]  w64_rd, w64_rs1, w64_rs2;
   logic [2:0]  w64_funct3, w64_fmt;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t exp_q[$];
   exp_t vecs[22];
   exp_t mon_e;

   assign in_pc64 = {32'h0, in_pc};

   always #5 clk = ~clk;

   decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
      .funct7(funct7), .imm(imm), .fmt(fmt), .rd_we(rd_we), .illegal(illegal)
   );

   decode_stage #(.XLEN(32), .ENABLE_M(1'b1)) dut_m (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(m_in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready),
      .out_pc(m_out_pc), .opcode(m_opcode), .rd(m_rd), .funct3(m_funct3), .rs1(m_rs1),
      .rs2(m_rs2), .funct7(m_funct7), .imm(m_imm), .fmt(m_fmt), .rd_we(m_rd_we),
      .illegal(m_illegal)
   );

   decode_stage #(.XLEN(64), .ENABLE_M(1'b0)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(w64_in_ready),
      .in_instr(in_instr), .in_pc(in_pc64), .out_valid(w64_out_valid), .out_ready(out_ready),
      .out_pc(w64_out_pc), .opcode(w64_opcode), .rd(w64_rd), .funct3(w64_funct3),
      .rs1(w64_rs1), .rs2(w64_rs2), .funct7(w64_funct7), .imm(w64_imm), .fmt(w64_fmt),
      .rd_we(w64_rd_we), .illegal(w64_illegal)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: one expected bundle per output handshake, in issue order.
   always @(negedge clk) begin
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1'b1, 1'b0);
         end else begin
            mon_e = exp_q.pop_front();
            check("opcode",  opcode,  mon_e.instr[6:0]);
            check("rd",      rd,      mon_e.instr[11:7]);
            check("funct3",  funct3,  mon_e.instr[14:12]);
            check("rs1",     rs1,     mon_e.instr[19:15]);
            check("rs2",     rs2,     mon_e.instr[24:20]);
            check("funct7",  funct7,  mon_e.instr[31:25]);
            check("out_pc",  out_pc,  mon_e.pc);
            check("imm",     imm,     mon_e.imm64[31:0]);
            check("fmt",     fmt,     mon_e.fmt);
            check("rd_we",   rd_we,   mon_e.rd_we);
            check("illegal", illegal, mon_e.ill);
            check("m_fmt",     m_fmt,     mon_e.fmt_m);
            check("m_rd_we",   m_rd_we,   mon_e.rd_we_m);
            check("m_illegal", m_illegal, mon_e.ill_m);
            check("imm64",     w64_imm,   mon_e.imm64);
         end
      end
   end

   task automatic send(input int k);
      bit took;
      exp_t e;
      e          = vecs[k];
      e.pc       = 32'h1000 + 32'(k) * 4;
      in_valid   = 1'b1;
      in_instr   = e.instr;
      in_pc      = e.pc;
      took       = 1'b0;
      for (int c = 0; c < 50 && !took; c++) begin
         @(negedge clk);
         if (in_ready && !flush) took = 1'b1;
      end
      if (!took) begin
         check("send_timeout", 1'b0, 1'b1);
      end else begin
         exp_q.push_back(e);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_fmt"},       fmt,       3'd7);
      check({tag, "_imm"},       imm,       32'h0);
      check({tag, "_fields"},    {funct7, rs2, rs1, funct3, rd, opcode}, 32'h0);
      check({tag, "_out_pc"},    out_pc,    32'h0);
      check({tag, "_rd_we_ill"}, {rd_we, illegal}, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] snap_fields, snap_pc, snap_imm;

   initial begin
      //          instr         pc  imm64                   fmt fmt_m we we_m ill ill_m
      vecs[0]  = '{32'h0040A283, 0, 64'h4,                   1, 1, 1, 1, 0, 0}; // lw x5,4(x1)
      vecs[1]  = '{32'hFE112E23, 0, 64'hFFFFFFFFFFFFFFFC,    2, 2, 0, 0, 0, 0}; // sw x1,-4(x2)
      vecs[2]  = '{32'hFE000CE3, 0, 64'hFFFFFFFFFFFFFFF8,    3, 3, 0, 0, 0, 0}; // beq -8
      vecs[3]  = '{32'h12345537, 0, 64'h12345000,            4, 4, 1, 1, 0, 0}; // lui x10
      vecs[4]  = '{32'h800002B7, 0, 64'hFFFFFFFF80000000,    4, 4, 1, 1, 0, 0}; // lui x5,0x80000
      vecs[5]  = '{32'h00000000, 0, 64'h0,                   7, 7, 0, 0, 1, 1};
      vecs[6]  = '{32'h02208033, 0, 64'h0,                   7, 0, 0, 0, 1, 0}; // mul x0
      vecs[7]  = '{32'h002081B3, 0, 64'h0,                   0, 0, 1, 1, 0, 0}; // add x3
      vecs[8]  = '{32'h40208133, 0, 64'h0,                   0, 0, 1, 1, 0, 0}; // sub x2
      vecs[9]  = '{32'h40209133, 0, 64'h0,                   7, 7, 0, 0, 1, 1}; // alt sll
      vecs[10] = '{32'h4030D293, 0, 64'h403,                 1, 1, 1, 1, 0, 0}; // srai x5,x1,3
      vecs[11] = '{32'h40309293, 0, 64'h0,                   7, 7, 0, 0, 1, 1}; // alt slli
      vecs[12] = '{32'h008000EF, 0, 64'h8,                   5, 5, 1, 1, 0, 0}; // jal x1,+8
      vecs[13] = '{32'h00000073, 0, 64'h0,                   1, 1, 0, 0, 0, 0}; // ecall
      vecs[14] = '{32'h0000000F, 0, 64'h0,                   1, 1, 0, 0, 0, 0}; // fence
      vecs[15] = '{32'h00000013, 0, 64'h0,                   1, 1, 0, 0, 0, 0}; // nop, rd=0
      vecs[16] = '{32'hFFF100E7, 0, 64'hFFFFFFFFFFFFFFFF,    1, 1, 1, 1, 0, 0}; // jalr x1,-1(x2)
      vecs[17] = '{32'hFFFFF097, 0, 64'hFFFFFFFFFFFFF000,    4, 4, 1, 1, 0, 0}; // auipc x1
      vecs[18] = '{32'h0000000B, 0, 64'h0,                   7, 7, 0, 0, 1, 1}; // custom-0
      vecs[19] = '{32'h00000001, 0, 64'h0,                   7, 7, 0, 0, 1, 1}; // low bits != 11
      vecs[20] = '{32'h022081B3, 0, 64'h0,                   7, 0, 0, 1, 1, 0}; // mul x3
      vecs[21] = '{32'h300022F3, 0, 64'h300,                 1, 1, 1, 1, 0, 0}; // csrrs x5,mstatus

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_instr = 32'h0; in_pc = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_reset_state("reset");
      check("reset_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Full-throughput stream of every vector.
      for (int k = 0; k < 22; k++) send(k);

      // Stall: hold the first bundle while the next two wait upstream.
      send(0);
      out_ready = 1'b0;
      fork
         begin
            send(1);
            send(2);
         end
         begin
            @(negedge clk);
            snap_fields = {funct7, rs2, rs1, funct3, rd, opcode};
            snap_pc     = out_pc;
            snap_imm    = imm;
            for (int c = 0; c < 3; c++) begin
               @(negedge clk);
               check("stall_in_ready",  in_ready,  1'b0);
               check("stall_out_valid", out_valid, 1'b1);
               check("stall_fields", {funct7, rs2, rs1, funct3, rd, opcode}, snap_fields);
               check("stall_pc",  out_pc, snap_pc);
               check("stall_imm", imm,    snap_imm);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;

      // Flush while a new instruction is offered: held one drains, offered one is dropped.
      send(3);
      in_valid = 1'b1; in_instr = vecs[4].instr; flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", in_ready, 1'b1);
      @(posedge clk);
      #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      check("flush_out_valid", out_valid, 1'b0);

      // Flush discards a stalled bundle that downstream never took.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      send(5);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      void'(exp_q.pop_back());
      @(negedge clk);
      check("flush_stalled_out_valid", out_valid, 1'b0);
      check("flush_stalled_in_ready",  in_ready,  1'b1);

      // Reset in the middle of a stall clears everything.
      @(posedge clk);
      #1;
      send(7);
      @(negedge clk);
      check("prereset_out_valid", out_valid, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      void'(exp_q.pop_back());
      @(negedge clk);
      check_reset_state("midstall_reset");
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Last stream after the reset, then drain.
      send(10);
      send(20);
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
      @(negedge clk);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("final_out_valid", out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
